// File: rtl/barrel_shifter_unit_if.sv
// Operand, amount and result bundle for the three-lane barrel shift unit.
// The master drives operands and amounts; the slave (the shift unit) returns registered results.
interface barrel_shifter_unit_if #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
);
    logic [WIDTH-1:0] in_left_shift;
    logic [SHW-1:0]   shift_value_left_shift;
    logic [WIDTH-1:0] in_right_shift;
    logic [SHW-1:0]   shift_value_right_shift;
    logic [WIDTH-1:0] in_uni_shift;
    logic             left_shift_en;
    logic             right_shift_en;
    logic [SHW-1:0]   shift_value_uni_left_shift;
    logic [SHW-1:0]   shift_value_uni_right_shift;
    logic [WIDTH-1:0] out_left_shift;
    logic [WIDTH-1:0] out_right_shift;
    logic [WIDTH-1:0] out_uni_shift;

    modport master (
        output in_left_shift, shift_value_left_shift,
        output in_right_shift, shift_value_right_shift,
        output in_uni_shift, left_shift_en, right_shift_en,
        output shift_value_uni_left_shift, shift_value_uni_right_shift,
        input  out_left_shift, out_right_shift, out_uni_shift
    );

    modport slave (
        input  in_left_shift, shift_value_left_shift,
        input  in_right_shift, shift_value_right_shift,
        input  in_uni_shift, left_shift_en, right_shift_en,
        input  shift_value_uni_left_shift, shift_value_uni_right_shift,
        output out_left_shift, out_right_shift, out_uni_shift
    );
endinterface

// File: rtl/barrel_shifter_unit.sv
// Registered 32-bit logical barrel shifter with independent left, right and universal lanes.
// Each lane is a log2-stage mux barrel; all results appear one cycle after sampling.
module barrel_shift_core #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5,
    parameter bit LEFT  = 1'b1
) (
    input  logic [WIDTH-1:0] data,
    input  logic [SHW-1:0]   amount,
    output logic [WIDTH-1:0] result
);
    logic [WIDTH-1:0] stage [SHW+1];

    assign stage[0] = data;

    // Stage k moves the word by 2^k positions when amount bit k is set, zero-filling the vacated end.
    for (genvar k = 0; k < SHW; k++) begin : g_stage
        localparam int STEP = 1 << k;
        logic [WIDTH-1:0] moved;
        if (LEFT) begin : g_left
            assign moved = {stage[k][WIDTH-1-STEP:0], {STEP{1'b0}}};
        end else begin : g_right
            assign moved = {{STEP{1'b0}}, stage[k][WIDTH-1:STEP]};
        end
        assign stage[k+1] = amount[k] ? moved : stage[k];
    end

    assign result = stage[SHW];
endmodule

module barrel_shifter_unit #(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input logic                 clk,
    input logic                 rst,
    barrel_shifter_unit_if.slave bus
);
    logic [WIDTH-1:0] left_result;
    logic [WIDTH-1:0] right_result;
    logic [WIDTH-1:0] uni_left_result;
    logic [WIDTH-1:0] uni_right_input;
    logic [WIDTH-1:0] uni_right_result;
    logic [WIDTH-1:0] uni_result;

    barrel_shift_core #(.WIDTH(WIDTH), .SHW(SHW), .LEFT(1'b1)) left_lane (
        .data   (bus.in_left_shift),
        .amount (bus.shift_value_left_shift),
        .result (left_result)
    );

    barrel_shift_core #(.WIDTH(WIDTH), .SHW(SHW), .LEFT(1'b0)) right_lane (
        .data   (bus.in_right_shift),
        .amount (bus.shift_value_right_shift),
        .result (right_result)
    );

    barrel_shift_core #(.WIDTH(WIDTH), .SHW(SHW), .LEFT(1'b1)) uni_left_lane (
        .data   (bus.in_uni_shift),
        .amount (bus.shift_value_uni_left_shift),
        .result (uni_left_result)
    );

    // The right barrel of the universal lane sees the left-shifted word only when left is enabled,
    // so a disabled direction's amount can never reach the result.
    assign uni_right_input = bus.left_shift_en ? uni_left_result : bus.in_uni_shift;

    barrel_shift_core #(.WIDTH(WIDTH), .SHW(SHW), .LEFT(1'b0)) uni_right_lane (
        .data   (uni_right_input),
        .amount (bus.shift_value_uni_right_shift),
        .result (uni_right_result)
    );

    assign uni_result = bus.right_shift_en ? uni_right_result : uni_right_input;

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.out_left_shift  <= '0;
            bus.out_right_shift <= '0;
            bus.out_uni_shift   <= '0;
        end else begin
            bus.out_left_shift  <= left_result;
            bus.out_right_shift <= right_result;
            bus.out_uni_shift   <= uni_result;
        end
    end
endmodule

// File: tb/tb_barrel_shifter_unit.sv
// Directed self-checking bench for barrel_shifter_unit: reset, each lane, amount sweep, mid-stream reset.
module tb_barrel_shifter_unit;
    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    barrel_shifter_unit_if #(.WIDTH(32), .SHW(5)) bus ();

    barrel_shifter_unit #(.WIDTH(32), .SHW(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after a rising edge and outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_all(input logic [31:0] l_in, input logic [4:0] l_amt,
                             input logic [31:0] r_in, input logic [4:0] r_amt,
                             input logic [31:0] u_in, input logic [1:0] en,
                             input logic [4:0] u_l, input logic [4:0] u_r);
        bus.in_left_shift               = l_in;
        bus.shift_value_left_shift      = l_amt;
        bus.in_right_shift              = r_in;
        bus.shift_value_right_shift     = r_amt;
        bus.in_uni_shift                = u_in;
        bus.left_shift_en               = en[1];
        bus.right_shift_en              = en[0];
        bus.shift_value_uni_left_shift  = u_l;
        bus.shift_value_uni_right_shift = u_r;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_all(32'hDEAD_BEEF, 5'd3, 32'hCAFE_F00D, 5'd7, 32'hA5A5_A5A5, 2'b11, 5'd1, 5'd2);
        tick();
        compared++;
        if (bus.out_left_shift !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_left: got %h expected %h", bus.out_left_shift, 32'h0);
        end
        compared++;
        if (bus.out_right_shift !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_right: got %h expected %h", bus.out_right_shift, 32'h0);
        end
        compared++;
        if (bus.out_uni_shift !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL reset_uni: got %h expected %h", bus.out_uni_shift, 32'h0);
        end
        rst = 1'b0;
    endtask

    task automatic test_left();
        logic [31:0] vin  [3] = '{32'h0000_0001, 32'hFFFF_FFFF, 32'h8421_1248};
        logic [4:0]  vamt [3] = '{5'd31, 5'd4, 5'd0};
        logic [31:0] vexp [3] = '{32'h8000_0000, 32'hFFFF_FFF0, 32'h8421_1248};
        for (int i = 0; i < 3; i++) begin
            drive_all(vin[i], vamt[i], 32'h0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0);
            tick();
            compared++;
            if (bus.out_left_shift !== vexp[i]) begin
                mismatched++;
                $display("[TB] FAIL left_%0d: got %h expected %h", i, bus.out_left_shift, vexp[i]);
            end
        end
    endtask

    task automatic test_right();
        logic [31:0] vin  [3] = '{32'h8000_0000, 32'hF000_000F, 32'h1357_9BDF};
        logic [4:0]  vamt [3] = '{5'd31, 5'd4, 5'd0};
        logic [31:0] vexp [3] = '{32'h0000_0001, 32'h0F00_0000, 32'h1357_9BDF};
        for (int i = 0; i < 3; i++) begin
            drive_all(32'h0, 5'd0, vin[i], vamt[i], 32'h0, 2'b00, 5'd0, 5'd0);
            tick();
            compared++;
            if (bus.out_right_shift !== vexp[i]) begin
                mismatched++;
                $display("[TB] FAIL right_%0d: got %h expected %h", i, bus.out_right_shift, vexp[i]);
            end
        end
    endtask

    // Last two vectors load the disabled direction with a large amount that must be ignored.
    task automatic test_uni();
        logic [1:0]  ven  [6] = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b00, 2'b10};
        logic [4:0]  vl   [6] = '{5'd0, 5'd8, 5'd0, 5'd8, 5'd31, 5'd4};
        logic [4:0]  vr   [6] = '{5'd0, 5'd0, 5'd8, 5'd8, 5'd31, 5'd31};
        logic [31:0] vexp [6] = '{32'h1234_5678, 32'h3456_7800, 32'h0012_3456,
                                  32'h0034_5678, 32'h1234_5678, 32'h2345_6780};
        for (int i = 0; i < 6; i++) begin
            drive_all(32'h0, 5'd0, 32'h0, 5'd0, 32'h1234_5678, ven[i], vl[i], vr[i]);
            tick();
            compared++;
            if (bus.out_uni_shift !== vexp[i]) begin
                mismatched++;
                $display("[TB] FAIL uni_%0d: got %h expected %h", i, bus.out_uni_shift, vexp[i]);
            end
        end
    endtask

    // Back-to-back vectors every cycle; expected values come from a shift-operator reference model.
    task automatic test_sweep();
        logic [31:0] a, b, c, exp_l, exp_r, exp_u, tmp;
        logic [1:0]  en;
        logic [4:0]  amt, amt_r;
        for (int i = 0; i < 32; i++) begin
            a     = $urandom;
            b     = $urandom;
            c     = $urandom;
            amt   = 5'(i);
            amt_r = 5'(31 - i);
            en    = 2'(i % 4);
            exp_l = a << amt;
            exp_r = b >> amt;
            tmp   = en[1] ? (c << amt) : c;
            exp_u = en[0] ? (tmp >> amt_r) : tmp;
            drive_all(a, amt, b, amt, c, en, amt, amt_r);
            tick();
            compared++;
            if (bus.out_left_shift !== exp_l) begin
                mismatched++;
                $display("[TB] FAIL sweep_left amt=%0d: got %h expected %h", i, bus.out_left_shift, exp_l);
            end
            compared++;
            if (bus.out_right_shift !== exp_r) begin
                mismatched++;
                $display("[TB] FAIL sweep_right amt=%0d: got %h expected %h", i, bus.out_right_shift, exp_r);
            end
            compared++;
            if (bus.out_uni_shift !== exp_u) begin
                mismatched++;
                $display("[TB] FAIL sweep_uni amt=%0d en=%b: got %h expected %h", i, en, bus.out_uni_shift, exp_u);
            end
        end
    endtask

    task automatic test_reset_midstream();
        drive_all(32'h0000_00FF, 5'd8, 32'hFF00_0000, 5'd8, 32'h1234_5678, 2'b10, 5'd4, 5'd0);
        tick();
        compared++;
        if (bus.out_left_shift !== 32'h0000_FF00 || bus.out_right_shift !== 32'h00FF_0000 ||
            bus.out_uni_shift !== 32'h2345_6780) begin
            mismatched++;
            $display("[TB] FAIL midstream_before: got %h/%h/%h expected 0000ff00/00ff0000/23456780",
                     bus.out_left_shift, bus.out_right_shift, bus.out_uni_shift);
        end
        rst = 1'b1;
        drive_all(32'h0000_0003, 5'd1, 32'h0000_0030, 5'd4, 32'hFFFF_FFFF, 2'b11, 5'd16, 5'd16);
        tick();
        compared++;
        if (bus.out_left_shift !== 32'h0 || bus.out_right_shift !== 32'h0 || bus.out_uni_shift !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL midstream_reset: got %h/%h/%h expected 0/0/0",
                     bus.out_left_shift, bus.out_right_shift, bus.out_uni_shift);
        end
        rst = 1'b0;
        drive_all(32'h0000_0003, 5'd1, 32'h0000_0030, 5'd4, 32'hFFFF_FFFF, 2'b11, 5'd16, 5'd16);
        tick();
        compared++;
        if (bus.out_left_shift !== 32'h0000_0006 || bus.out_right_shift !== 32'h0000_0003 ||
            bus.out_uni_shift !== 32'h0000_FFFF) begin
            mismatched++;
            $display("[TB] FAIL midstream_after: got %h/%h/%h expected 00000006/00000003/0000ffff",
                     bus.out_left_shift, bus.out_right_shift, bus.out_uni_shift);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        drive_all(32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 2'b00, 5'd0, 5'd0);
        @(negedge clk);
        test_reset();
        test_left();
        test_right();
        test_uni();
        test_sweep();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
